// File: rtl/fsm_pkg.sv
// State encoding for the APB request arbiter FSM.
package fsm_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_POP       = 3'd1,
    ARB_LOAD      = 3'd2,
    ARB_READY     = 3'd3,
    ARB_WAIT_RESP = 3'd4
  } apb_arb_states_e;

endpackage

// File: rtl/ni_pkg.sv
// Network-interface packet formats shared by requesters, arbiter and apb_manager.
package ni_pkg;

  typedef struct packed {
    logic [1:0]  flit_type;
    logic [31:0] data_bits;
  } flit_s;

  typedef struct packed {
    flit_s       header;
    flit_s [2:0] body_flit;
  } req_packet_s;

  typedef struct packed {
    flit_s       header;
    flit_s [2:0] body_flit;
  } resp_packet_s;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-FIFO, manager-FIFO and status signals around the arbiter.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import ni_pkg::*;

  req_packet_s  [NUM_REQ-1:0] req_pkt_i;
  logic         [NUM_REQ-1:0] req_empty_i;
  logic         [NUM_REQ-1:0] req_rreq_o;
  req_packet_s                mgr_pkt_o;
  logic                       mgr_empty_o;
  logic                       mgr_rreq_i;
  resp_packet_s               mgr_resp_pkt_i;
  logic                       mgr_wreq_i;
  logic                       mgr_full_o;
  resp_packet_s               resp_pkt_o;
  logic         [NUM_REQ-1:0] resp_full_i;
  logic         [NUM_REQ-1:0] resp_wreq_o;
  logic         [NUM_REQ-1:0] grant_o;
  logic                       timeout_o;

  // Arbiter side
  modport master (
    input  req_pkt_i, req_empty_i, mgr_rreq_i, mgr_resp_pkt_i, mgr_wreq_i, resp_full_i,
    output req_rreq_o, mgr_pkt_o, mgr_empty_o, mgr_full_o, resp_pkt_o, resp_wreq_o,
           grant_o, timeout_o
  );

  // Requester FIFOs and apb_manager side
  modport slave (
    output req_pkt_i, req_empty_i, mgr_rreq_i, mgr_resp_pkt_i, mgr_wreq_i, resp_full_i,
    input  req_rreq_o, mgr_pkt_o, mgr_empty_o, mgr_full_o, resp_pkt_o, resp_wreq_o,
           grant_o, timeout_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, one-hot result.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Funnels NUM_REQ requester FIFO pairs into one apb_manager, one transaction at a time,
// with round-robin fairness and a response timeout that synthesises a PSLVERR reply.
module apb_req_arbiter
  import fsm_pkg::*;
  import ni_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_req_arbiter_if.master bus
);

  localparam int                PTR_W   = $clog2(NUM_REQ);
  localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  apb_arb_states_e    state;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] win;
  logic [NUM_REQ-1:0] req_vec;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  req_packet_s        pkt_q;
  logic [CNT_W-1:0]   cnt;
  logic               timed_out;

  logic in_wait;
  logic owner_full;
  logic mgr_push;
  logic err_push;
  logic push;
  logic to_hit;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (v[i]) idx = idx | PTR_W'(i);
    return idx;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
    return (cur == PTR_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
  endfunction

  // All-zero reply except PSLVERR, returned when the manager never answers
  function automatic resp_packet_s error_packet();
    resp_packet_s p;
    p = '0;
    p.body_flit[2].data_bits[12] = 1'b1;
    return p;
  endfunction

  assign req_vec = ~bus.req_empty_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req (req_vec),
    .ptr (rr_ptr),
    .gnt (win)
  );

  // Once timed out, a late manager reply is discarded and only the error reply may go out
  assign in_wait    = (state == ARB_WAIT_RESP);
  assign owner_full = bus.resp_full_i[owner];
  assign mgr_push   = in_wait && !timed_out && bus.mgr_wreq_i && !owner_full;
  assign err_push   = in_wait && timed_out && !owner_full;
  assign push       = mgr_push || err_push;
  assign to_hit     = in_wait && !timed_out && !mgr_push && (cnt == CNT_MAX);

  assign bus.req_rreq_o  = (state == ARB_POP) ? grant_q : '0;
  assign bus.resp_wreq_o = push ? grant_q : '0;
  assign bus.resp_pkt_o  = err_push ? error_packet() : bus.mgr_resp_pkt_i;
  assign bus.mgr_pkt_o   = pkt_q;
  assign bus.mgr_empty_o = (state != ARB_READY);
  assign bus.mgr_full_o  = in_wait ? owner_full : 1'b1;
  assign bus.grant_o     = grant_q;
  assign bus.timeout_o   = to_hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ARB_IDLE;
      grant_q   <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      pkt_q     <= '0;
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req_vec) begin
            grant_q <= win;
            owner   <= onehot_to_idx(win);
            state   <= ARB_POP;
          end
        end
        ARB_POP: state <= ARB_LOAD;
        ARB_LOAD: begin
          pkt_q <= bus.req_pkt_i[owner];
          state <= ARB_READY;
        end
        ARB_READY: begin
          if (bus.mgr_rreq_i) begin
            cnt       <= '0;
            timed_out <= 1'b0;
            state     <= ARB_WAIT_RESP;
          end
        end
        ARB_WAIT_RESP: begin
          if (push) begin
            grant_q   <= '0;
            rr_ptr    <= next_ptr(owner);
            timed_out <= 1'b0;
            state     <= ARB_IDLE;
          end else if (to_hit) begin
            timed_out <= 1'b1;
          end else if (!timed_out) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of NI requester FIFO pairs (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, giving the maximum cycles to wait for a manager response.
REQ-003 PCLK  in  1  sole clock; one clock, reset asynchronous active-low.
REQ-004 PRESETn  in  1  asynchronous active-low reset.
REQ-005 req_pkt_i  in  NUM_REQ x req_packet_s  requester FIFO read data, valid the cycle after its rreq.
REQ-006 req_empty_i  in  NUM_REQ  requester FIFO empty flags.
REQ-007 req_rreq_o  out  NUM_REQ  requester FIFO pop, one-hot or zero.
REQ-008 mgr_pkt_o  out  req_packet_s  packet presented to apb_manager.
REQ-009 mgr_empty_o  out  1  FIFO-empty view seen by apb_manager.
REQ-010 mgr_rreq_i  in  1  apb_manager pop.
REQ-011 mgr_resp_pkt_i  in  resp_packet_s  apb_manager response data.
REQ-012 mgr_wreq_i  in  1  apb_manager response push.
REQ-013 mgr_full_o  out  1  FIFO-full view seen by apb_manager.
REQ-014 resp_pkt_o  out  resp_packet_s  response data, broadcast to all response FIFOs.
REQ-015 resp_full_i  in  NUM_REQ  requester response FIFO full flags.
REQ-016 resp_wreq_o  out  NUM_REQ  response FIFO push, one-hot or zero.
REQ-017 grant_o  out  NUM_REQ  current owner, one-hot; zero when idle.
REQ-018 timeout_o  out  1  single-cycle pulse on response timeout.

Function
REQ-019 SHALL implement FSM states ARB_IDLE, ARB_POP, ARB_LOAD, ARB_READY and ARB_WAIT_RESP.
REQ-020 In ARB_IDLE with any req_empty_i low, SHALL pick the winner round-robin starting at rr_ptr, set grant_o, and go to ARB_POP.
REQ-021 In ARB_POP, SHALL assert req_rreq_o[owner] for exactly one cycle, then go to ARB_LOAD.
REQ-022 In ARB_LOAD, SHALL capture req_pkt_i[owner] into pkt_q, then go to ARB_READY.
REQ-023 mgr_pkt_o SHALL equal pkt_q at all times, held stable from ARB_READY until the next ARB_LOAD.
REQ-024 mgr_empty_o SHALL be 0 only in ARB_READY.
REQ-025 In ARB_READY, mgr_rreq_i SHALL move the FSM to ARB_WAIT_RESP and clear the timeout counter.
REQ-026 mgr_full_o SHALL equal resp_full_i[owner] in ARB_WAIT_RESP and be 1 in every other state.
REQ-027 In ARB_WAIT_RESP, mgr_wreq_i with mgr_full_o low SHALL pass combinationally to resp_wreq_o[owner] with resp_pkt_o = mgr_resp_pkt_i.
REQ-028 The same event SHALL set rr_ptr = (owner+1) mod NUM_REQ and move the FSM to ARB_IDLE.
REQ-029 In ARB_WAIT_RESP, the counter SHALL increment while no push occurs.
REQ-030 When the counter reaches TIMEOUT_CYC-1, SHALL pulse timeout_o and wait for resp_full_i[owner] low.
REQ-031 Then SHALL push a zero packet to the owner with body_flit[2].data_bits[12] (PSLVERR) = 1, advance rr_ptr, and return to ARB_IDLE.
REQ-032 Outside ARB_WAIT_RESP, mgr_wreq_i SHALL be dropped silently; mgr_rreq_i SHALL be ignored outside ARB_READY.
REQ-033 Only one transaction SHALL be outstanding; grant_o SHALL stay constant from ARB_POP to the response push.
REQ-034 The counter width SHALL be $clog2(TIMEOUT_CYC).
REQ-035 rr_ptr SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-036 On PRESETn low, SHALL immediately force state = ARB_IDLE, rr_ptr = 0, pkt_q = 0 and counter = 0.
REQ-037 Reset SHALL force outputs req_rreq_o = 0, resp_wreq_o = 0, grant_o = 0, mgr_empty_o = 1, mgr_full_o = 1 and timeout_o = 0.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no response generated.

Structure
REQ-039 apb_arb_states_e SHALL live in fsm_pkg; req_packet_s and resp_packet_s SHALL come from ni_pkg; no new constants.
REQ-040 One sub-module, rr_arbiter (NUM_REQ; inputs req, ptr; output one-hot gnt), SHALL be instantiated; the rest is flat.

Verification
REQ-041 Reset, all empty: mgr_empty_o = 1, grant_o = 0 indefinitely.
REQ-042 Requesters 0 and 2 non-empty, rr_ptr = 0: grant 0001 -> one pop -> mgr_empty_o falls in cycle 3. After the manager push, grant 0100 next; after that push, rr_ptr = 3.
REQ-043 All 4 requesters continuously non-empty: grants cycle 0,1,2,3,0, each holding exactly one transaction.
REQ-044 resp_full_i[owner] held high 10 cycles during WAIT_RESP: mgr_full_o = 1, no resp_wreq_o until full drops, then a single push with PRDATA intact.
REQ-045 Manager silent with TIMEOUT_CYC = 16: timeout_o pulses at cycle 16 of WAIT_RESP, error packet pushed with data_bits[12] = 1, and a later manager push is dropped.
REQ-046 PRESETn asserted in ARB_WAIT_RESP: all outputs are at reset values within the same cycle; after release, arbitration restarts at requester 0.
